// File: rtl/uart_rx.sv
// UART receiver: oversampled start detect, mid-bit sampling, optional parity and stop check.
// Presents each received word with parity and framing status on a one-clock rx_valid pulse.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 baud_in,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 rx_busy
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS);

  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e               state_q, state_d;
  logic                 baud_q;
  logic                 rx_meta_q, rx_s_q;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_bit_q, parity_bit_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_error_q, parity_error_d;
  logic                 frame_error_q, frame_error_d;
  logic                 rx_busy_q, rx_busy_d;
  logic                 tick;
  logic                 rx_s;
  logic                 parity_ok;

  assign tick      = baud_in & ~baud_q;
  assign rx_s      = rx_s_q;
  assign parity_ok = ((^shift_q) ^ parity_bit_q) == PARITY_ODD;

  // Line and baud registers reset to 1 so an idle-high line is not seen as a start bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      baud_q    <= 1'b1;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      baud_q    <= baud_in;
      rx_meta_q <= rx_serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      tick_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      parity_bit_q   <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      rx_busy_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      parity_bit_q   <= parity_bit_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
      rx_busy_q      <= rx_busy_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    tick_cnt_d     = tick_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    parity_bit_d   = parity_bit_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    parity_error_d = parity_error_q;
    frame_error_d  = frame_error_q;

    unique case (state_q)
      StIdle: begin
        if (tick && !rx_s) begin
          tick_cnt_d = '0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (tick_cnt_q == TickMid) begin
            if (rx_s) begin
              state_d = StIdle;
            end else begin
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              state_d    = StData;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (tick_cnt_q == TickLast) begin
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            if (bit_cnt_q == BitLast) begin
              state_d = PARITY_EN ? StParity : StStop;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          if (tick_cnt_q == TickLast) begin
            parity_bit_d = rx_s;
            tick_cnt_d   = '0;
            state_d      = StStop;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (tick_cnt_q == TickLast) begin
            rx_data_d      = shift_q;
            rx_valid_d     = 1'b1;
            parity_error_d = PARITY_EN & ~parity_ok;
            frame_error_d  = ~rx_s;
            tick_cnt_d     = '0;
            // A low stop bit means the line may be in break; wait for it to rise.
            state_d        = rx_s ? StIdle : StBreak;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      StBreak: begin
        if (tick && rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    rx_busy_d = (state_d != StIdle);
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign parity_error = parity_error_q;
  assign frame_error  = frame_error_q;
  assign rx_busy      = rx_busy_q;

endmodule
